// File: rtl/hdmi_video_pkg.sv
// Shared types and constants for the HDMI test-pattern path: pattern modes,
// colour-bar palette and default 640x480@60 timing.
package hdmi_video_pkg;

   typedef enum logic [1:0] {
      PAT_BARS     = 2'd0,
      PAT_CHECKER  = 2'd1,
      PAT_GRADIENT = 2'd2,
      PAT_SOLID    = 2'd3
   } pat_mode_e;

   localparam logic [23:0] BAR_RGB [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   // Bar k covers k*h_active/8 <= xm < (k+1)*h_active/8.
   function automatic logic [2:0] bar_index(input int unsigned xm, input int unsigned h_active);
      logic [2:0] idx;
      idx = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (xm >= (k * h_active) / 8) idx = 3'(k);
      end
      return idx;
   endfunction

endpackage

// File: rtl/hdmi_pattern_gen_if.sv
// Registered video output bundle of hdmi_pattern_gen (sync, de, RGB, coordinates).
interface hdmi_pattern_gen_if #(
   parameter int unsigned CW = 12
);
   logic          hsync;
   logic          vsync;
   logic          de;
   logic [7:0]    red;
   logic [7:0]    green;
   logic [7:0]    blue;
   logic [CW-1:0] x_o;
   logic [CW-1:0] y_o;
   logic          sof_o;
   logic [1:0]    mode_o;

   modport master (output hsync, vsync, de, red, green, blue, x_o, y_o, sof_o, mode_o);
   modport slave  (input  hsync, vsync, de, red, green, blue, x_o, y_o, sof_o, mode_o);
endinterface

// File: rtl/video_timing_cnt.sv
// Pixel/line counters with frame-wrap strobe and unregistered sync/de decode.
module video_timing_cnt #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b1,
   parameter int unsigned CW       = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   output logic [CW-1:0] cx_o,
   output logic [CW-1:0] cy_o,
   output logic          wrap_o,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          de_o
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
   logic          x_last, y_last;

   always_comb begin
      x_last = (cx_q == X_LAST);
      y_last = (cy_q == Y_LAST);
      cx_d   = cx_q;
      cy_d   = cy_q;
      if (en_i) begin
         if (x_last) begin
            cx_d = '0;
            cy_d = y_last ? '0 : cy_q + 1'b1;
         end else begin
            cx_d = cx_q + 1'b1;
         end
      end
      wrap_o  = en_i && x_last && y_last;
      hsync_o = (cx_q >= HS_START && cx_q < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_o = (cy_q >= VS_START && cy_q < VS_END) ? SYNC_POL : ~SYNC_POL;
      de_o    = (cx_q < X_ACT) && (cy_q < Y_ACT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

   assign cx_o = cx_q;
   assign cy_o = cy_q;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Video timing + test-pattern generator with frame-synchronous mode switching.
// Optional scrolling patterns via `define HDMI_PATTERN_GEN_ANIM_EN.
module hdmi_pattern_gen
   import hdmi_video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          SYNC_POL = 1'b1,
   parameter int unsigned CW       = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic [1:0]         mode_i,
   input  logic [23:0]        solid_rgb_i,
   hdmi_pattern_gen_if.master vid
);
   logic [CW-1:0] cx, cy;
   logic          wrap, hs_raw, vs_raw, de_raw;

   video_timing_cnt #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .SYNC_POL (SYNC_POL), .CW (CW)
   ) u_timing (
      .clk (clk), .rst_n (rst_n), .en_i (en_i),
      .cx_o (cx), .cy_o (cy), .wrap_o (wrap),
      .hsync_o (hs_raw), .vsync_o (vs_raw), .de_o (de_raw)
   );

   pat_mode_e     mode_q, mode_d;
   logic [CW-1:0] xe, xm;
   logic [23:0]   rgb;
`ifdef HDMI_PATTERN_GEN_ANIM_EN
   logic [7:0]    frame_cnt_q, frame_cnt_d;
`endif

   logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, sof_q, sof_d;
   logic [23:0]   rgb_q, rgb_d;
   logic [CW-1:0] x_q, x_d, y_q, y_d;
   logic [1:0]    mode_o_q, mode_o_d;

   always_comb begin
`ifdef HDMI_PATTERN_GEN_ANIM_EN
      xe          = cx + CW'(frame_cnt_q);
      frame_cnt_d = wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
`else
      xe          = cx;
`endif
      xm  = CW'(32'(xe) % H_ACTIVE);
      rgb = '0;
      unique case (mode_q)
         PAT_BARS:     rgb = BAR_RGB[bar_index(32'(xm), H_ACTIVE)];
         PAT_CHECKER:  rgb = (xe[5] ^ cy[5]) ? 24'hFFFFFF : 24'h000000;
         PAT_GRADIENT: rgb = {xe[7:0], cy[7:0], xe[7:0] + cy[7:0]};
         PAT_SOLID:    rgb = solid_rgb_i;
         default:      rgb = '0;
      endcase
      if (!de_raw) rgb = '0;

      mode_d   = mode_q;
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      de_d     = de_q;
      rgb_d    = rgb_q;
      x_d      = x_q;
      y_d      = y_q;
      sof_d    = sof_q;
      mode_o_d = mode_o_q;
      if (en_i) begin
         // Mode is sampled on the wrap cycle, so (0,0) is the first pixel in the new mode.
         if (wrap) mode_d = pat_mode_e'(mode_i);
         hsync_d  = hs_raw;
         vsync_d  = vs_raw;
         de_d     = de_raw;
         rgb_d    = rgb;
         x_d      = cx;
         y_d      = cy;
         sof_d    = (cx == '0) && (cy == '0);
         mode_o_d = mode_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= PAT_BARS;
         hsync_q     <= ~SYNC_POL;
         vsync_q     <= ~SYNC_POL;
         de_q        <= 1'b0;
         rgb_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         sof_q       <= 1'b0;
         mode_o_q    <= '0;
`ifdef HDMI_PATTERN_GEN_ANIM_EN
         frame_cnt_q <= '0;
`endif
      end else begin
         mode_q      <= mode_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         de_q        <= de_d;
         rgb_q       <= rgb_d;
         x_q         <= x_d;
         y_q         <= y_d;
         sof_q       <= sof_d;
         mode_o_q    <= mode_o_d;
`ifdef HDMI_PATTERN_GEN_ANIM_EN
         frame_cnt_q <= frame_cnt_d;
`endif
      end
   end

   assign vid.hsync  = hsync_q;
   assign vid.vsync  = vsync_q;
   assign vid.de     = de_q;
   assign vid.red    = rgb_q[23:16];
   assign vid.green  = rgb_q[15:8];
   assign vid.blue   = rgb_q[7:0];
   assign vid.x_o    = x_q;
   assign vid.y_o    = y_q;
   assign vid.sof_o  = sof_q;
   assign vid.mode_o = mode_o_q;

endmodule
